rggen_register_access_controller: RTL and testbench
===================================================

# rggen_register_access_controller

Downstream companion of the APB host interface in the register block. Consumes the generic host command (valid/write/read/address/data/mask), broadcasts a registered, held access to all register instances and collects their ready/read-data/status. Produces one single-cycle response per command, covering decode errors for unmapped addresses and an optional timeout. Its response outputs drive the host interface's response_ready/read_data/status inputs.

## Interface
- DATA_WIDTH, 32, data bus width; multiple of 8
- LOCAL_ADDRESS_WIDTH, 16, register-block address width
- TOTAL_REGISTERS, 1, number of register instances; ≥1
- TIMEOUT_CYCLES, 0, maximum ACCESS cycles before SLAVE_ERROR; 0 disables the timeout
- clk  input  1  clock
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low
- i_command_valid  input  1  host command present
- i_write  input  1  write command
- i_read  input  1  read command
- i_address  input  LOCAL_ADDRESS_WIDTH  access address
- i_write_data  input  DATA_WIDTH  write data
- i_write_mask  input  DATA_WIDTH  bit-level write mask
- o_response_ready  output  1  one-cycle response strobe
- o_read_data  output  DATA_WIDTH  response read data
- o_status  output  2  response status
- o_register_valid  output  1  access in progress to registers
- o_register_write  output  1  latched write flag
- o_register_address  output  LOCAL_ADDRESS_WIDTH  latched address
- o_register_write_data  output  DATA_WIDTH  latched write data
- o_register_write_mask  output  DATA_WIDTH  latched mask
- i_register_active  input  TOTAL_REGISTERS  register i decodes the address
- i_register_ready  input  TOTAL_REGISTERS  register i completes
- i_register_read_data  input  DATA_WIDTH*TOTAL_REGISTERS  flattened, register i at [i*DATA_WIDTH+:DATA_WIDTH]
- i_register_status  input  2*TOTAL_REGISTERS  flattened status

## Operation
- Status encoding: OKAY=2'b00, SLAVE_ERROR=2'b01, DECODE_ERROR=2'b11; bit 0 means error.
- FSM states IDLE, ACCESS, RESPOND.
- IDLE: i_command_valid & (i_read | i_write) → latch write/address/data/mask, clear timeout counter, go to ACCESS. Otherwise stay.
- ACCESS: o_register_valid=1 with latched fields held stable. Let hit = i_register_active & i_register_ready. Exits, in priority order:
  - No bit of i_register_active set → DECODE_ERROR, read data 0.
  - Any hit → status = OR of hit registers' status; read data = OR of hit registers' read data, forced 0 on write.
  - TIMEOUT_CYCLES≠0 and counter == TIMEOUT_CYCLES-1 → SLAVE_ERROR, read data 0.
  - Otherwise counter++.
- Every exit captures status/data into output registers and goes to RESPOND.
- RESPOND: o_response_ready=1 for exactly one cycle; i_command_valid is ignored in this state; next state IDLE unconditionally.
- A command dropped during ACCESS is still completed and responded; the response is emitted regardless.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. When the timeout and a ready occur in the same cycle, ready wins.

## Timing
- Reset value of every output is 0; state resets to IDLE and the counter to 0. Reset asserted mid-access aborts immediately with no response.
- Minimum latency: command at cycle N → o_register_valid at N+1 → ready sampled at N+1 → o_response_ready at N+2. This gives one APB wait state.
- o_read_data and o_status are valid only while o_response_ready=1 and are held until the next capture.
- Back-to-back: a new command is accepted in the IDLE cycle right after RESPOND.

## Structure
- rggen_rtl_pkg holds the status typedef/constants and the FSM state typedef.
- Sub-module rggen_or_reducer (parameters WIDTH, N) performs the masked OR reduction of read data and status.

## Test plan
- Read addr 0x04, register 1 active and ready at once with 0xDEADBEEF/OKAY → o_response_ready at N+2, o_read_data=0xDEADBEEF, o_status=00.
- Write addr 0x10, data 0x12345678, mask 0x0000FFFF, ready after 3 cycles → latched fields stable for all 3 cycles, response at N+4 with read data 0 and OKAY.
- Read addr 0xFF0, no register active → DECODE_ERROR (2'b11), read data 0, response at N+2.
- TIMEOUT_CYCLES=4, active but never ready → SLAVE_ERROR at N+5. A repeat with ready in the 4th ACCESS cycle → OKAY.
- APB-style back-to-back read then write with i_command_valid held high across RESPOND → exactly two responses, second command accepted in the IDLE cycle.
- rst_n asserted during ACCESS → all outputs 0 asynchronously, no response pulse; next command after release completes normally.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// rtl/rggen_rtl_pkg.sv - shared status and FSM state types for the register block
package rggen_rtl_pkg;

    // Bit 0 set marks an error response.
    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_SLAVE_ERROR  = 2'b01,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        RESPOND = 2'b10
    } rggen_state_e;

endpackage

// File: rtl/rggen_or_reducer.sv
// rtl/rggen_or_reducer.sv - OR of the selected WIDTH-bit lanes of a flattened bus
module rggen_or_reducer #(
    parameter int WIDTH = 1,
    parameter int N     = 1
)(
    input  logic [N-1:0]       select,
    input  logic [WIDTH*N-1:0] data,
    output logic [WIDTH-1:0]   result
);

    always_comb begin
        result = '0;
        for (int i = 0; i < N; i++) begin
            if (select[i]) begin
                result = result | data[i*WIDTH+:WIDTH];
            end
        end
    end

endmodule

// File: rtl/rggen_register_access_controller.sv
// rtl/rggen_register_access_controller.sv - broadcasts a held host access to registers and returns one response
module rggen_register_access_controller
    import rggen_rtl_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int LOCAL_ADDRESS_WIDTH = 16,
    parameter int TOTAL_REGISTERS     = 1,
    parameter int TIMEOUT_CYCLES      = 0
)(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_command_valid,
    input  logic                            i_write,
    input  logic                            i_read,
    input  logic [LOCAL_ADDRESS_WIDTH-1:0]  i_address,
    input  logic [DATA_WIDTH-1:0]           i_write_data,
    input  logic [DATA_WIDTH-1:0]           i_write_mask,
    output logic                            o_response_ready,
    output logic [DATA_WIDTH-1:0]           o_read_data,
    output logic [1:0]                      o_status,
    output logic                            o_register_valid,
    output logic                            o_register_write,
    output logic [LOCAL_ADDRESS_WIDTH-1:0]  o_register_address,
    output logic [DATA_WIDTH-1:0]           o_register_write_data,
    output logic [DATA_WIDTH-1:0]           o_register_write_mask,
    input  logic [TOTAL_REGISTERS-1:0]      i_register_active,
    input  logic [TOTAL_REGISTERS-1:0]      i_register_ready,
    input  logic [DATA_WIDTH*TOTAL_REGISTERS-1:0] i_register_read_data,
    input  logic [2*TOTAL_REGISTERS-1:0]    i_register_status
);

    localparam int COUNTER_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES > 0) ? COUNTER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    rggen_state_e               state;
    rggen_state_e               state_next;
    logic [COUNTER_WIDTH-1:0]   counter;
    logic [TOTAL_REGISTERS-1:0] hit;
    logic [DATA_WIDTH-1:0]      hit_read_data;
    logic [1:0]                 hit_status;
    logic                       timeout;
    logic                       start;
    logic                       capture;
    logic [DATA_WIDTH-1:0]      capture_data;
    logic [1:0]                 capture_status;

    assign hit     = i_register_active & i_register_ready;
    assign timeout = (TIMEOUT_CYCLES > 0) && (counter == TIMEOUT_LAST);

    rggen_or_reducer #(.WIDTH(DATA_WIDTH), .N(TOTAL_REGISTERS)) u_data_reducer (
        .select (hit),
        .data   (i_register_read_data),
        .result (hit_read_data)
    );

    rggen_or_reducer #(.WIDTH(2), .N(TOTAL_REGISTERS)) u_status_reducer (
        .select (hit),
        .data   (i_register_status),
        .result (hit_status)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Exit priority in ACCESS: decode miss, then a ready hit, then timeout.
    always_comb begin
        state_next     = state;
        start          = 1'b0;
        capture        = 1'b0;
        capture_data   = '0;
        capture_status = RGGEN_OKAY;
        case (state)
            IDLE: begin
                if (i_command_valid && (i_read || i_write)) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = RESPOND;
                capture    = 1'b1;
                if (i_register_active == '0) begin
                    capture_status = RGGEN_DECODE_ERROR;
                end else if (hit != '0) begin
                    capture_status = hit_status;
                    capture_data   = o_register_write ? '0 : hit_read_data;
                end else if (timeout) begin
                    capture_status = RGGEN_SLAVE_ERROR;
                end else begin
                    state_next = ACCESS;
                    capture    = 1'b0;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter               <= '0;
            o_register_write      <= 1'b0;
            o_register_address    <= '0;
            o_register_write_data <= '0;
            o_register_write_mask <= '0;
            o_read_data           <= '0;
            o_status              <= '0;
        end else begin
            if (start) begin
                counter               <= '0;
                o_register_write      <= i_write;
                o_register_address    <= i_address;
                o_register_write_data <= i_write_data;
                o_register_write_mask <= i_write_mask;
            end else if (state == ACCESS) begin
                counter <= counter + 1'b1;
            end
            if (capture) begin
                o_read_data <= capture_data;
                o_status    <= capture_status;
            end
        end
    end

    assign o_register_valid = (state == ACCESS);
    assign o_response_ready = (state == RESPOND);

endmodule

// File: tb/tb_rggen_register_access_controller.sv
// tb/tb_rggen_register_access_controller.sv - scoreboard bench for rggen_register_access_controller
module tb_rggen_register_access_controller;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NR = 3;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_command_valid;
    logic              i_write;
    logic              i_read;
    logic [AW-1:0]     i_address;
    logic [DW-1:0]     i_write_data;
    logic [DW-1:0]     i_write_mask;
    logic              o_response_ready;
    logic [DW-1:0]     o_read_data;
    logic [1:0]        o_status;
    logic              o_register_valid;
    logic              o_register_write;
    logic [AW-1:0]     o_register_address;
    logic [DW-1:0]     o_register_write_data;
    logic [DW-1:0]     o_register_write_mask;
    logic [NR-1:0]     i_register_active;
    logic [NR-1:0]     i_register_ready;
    logic [DW*NR-1:0]  i_register_read_data;
    logic [2*NR-1:0]   i_register_status;

    rggen_register_access_controller #(
        .DATA_WIDTH(DW), .LOCAL_ADDRESS_WIDTH(AW), .TOTAL_REGISTERS(NR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_command_valid(i_command_valid), .i_write(i_write), .i_read(i_read),
        .i_address(i_address), .i_write_data(i_write_data), .i_write_mask(i_write_mask),
        .o_response_ready(o_response_ready), .o_read_data(o_read_data), .o_status(o_status),
        .o_register_valid(o_register_valid), .o_register_write(o_register_write),
        .o_register_address(o_register_address), .o_register_write_data(o_register_write_data),
        .o_register_write_mask(o_register_write_mask),
        .i_register_active(i_register_active), .i_register_ready(i_register_ready),
        .i_register_read_data(i_register_read_data), .i_register_status(i_register_status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    status;
        logic [DW-1:0] data;
        int            cycle;
    } resp_t;

    resp_t         exp_q[$];
    int            cyc = 0;
    int            vectors = 0;
    int            errors = 0;
    logic          exp_access = 1'b0;
    logic          exp_write;
    logic [AW-1:0] exp_address;
    logic [DW-1:0] exp_wdata;
    logic [DW-1:0] exp_wmask;
    logic [DW-1:0] reg_rd [NR];
    logic [1:0]    reg_st [NR];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        resp_t r;
        vectors++;
        if (o_register_valid !== exp_access) begin
            errors++;
            $display("FAIL access_flag cycle %0d: got %b want %b", cyc, o_register_valid, exp_access);
        end
        if (o_register_valid === 1'b1) begin
            vectors++;
            if ({o_register_write, o_register_address, o_register_write_data, o_register_write_mask}
                !== {exp_write, exp_address, exp_wdata, exp_wmask}) begin
                errors++;
                $display("FAIL latched_fields cycle %0d: got w=%b a=%h d=%h m=%h want w=%b a=%h d=%h m=%h",
                         cyc, o_register_write, o_register_address, o_register_write_data,
                         o_register_write_mask, exp_write, exp_address, exp_wdata, exp_wmask);
            end
        end
        if (o_response_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_response cycle %0d: got status=%b data=%h want no response",
                         cyc, o_status, o_read_data);
            end else begin
                r = exp_q.pop_front();
                if ({o_status, o_read_data} !== {r.status, r.data} || cyc != r.cycle) begin
                    errors++;
                    $display("FAIL response: got status=%b data=%h cycle=%0d want status=%b data=%h cycle=%0d",
                             o_status, o_read_data, cyc, r.status, r.data, r.cycle);
                end
            end
        end
    end

    task automatic junk_regs();
        i_register_active    = NR'($urandom);
        i_register_ready     = NR'($urandom);
        i_register_read_data = {$urandom, $urandom, $urandom};
        i_register_status    = 6'($urandom);
    endtask

    task automatic drive_regs(input logic [NR-1:0] active, input logic [NR-1:0] rdy);
        i_register_active = active;
        i_register_ready  = rdy | (NR'($urandom) & ~active);
        for (int i = 0; i < NR; i++) begin
            i_register_read_data[i*DW+:DW] = reg_rd[i];
            i_register_status[2*i+:2]      = reg_st[i];
        end
    endtask

    // Starts in an IDLE or RESPOND cycle (early only after a previous command),
    // returns #1 into the RESPOND cycle of this command.
    task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] wmask, input logic [NR-1:0] active,
                           input logic [NR-1:0] rdy_in, input int delay, input bit early, input int gap);
        logic [NR-1:0] rdy;
        int            len;
        int            n;
        resp_t         r;
        rdy = rdy_in & active;
        if (rdy == '0) rdy = active & (~active + NR'(1));
        if (!early) begin
            i_command_valid = 1'b0;
            i_read = 1'($urandom);
            i_write = 1'($urandom);
            @(posedge clk); #1;
            for (int g = 0; g < gap; g++) begin
                i_command_valid = 1'b1;
                i_read = 1'b0;
                i_write = 1'b0;
                i_address = AW'($urandom);
                junk_regs();
                @(posedge clk); #1;
            end
        end
        exp_write = wr; exp_address = addr; exp_wdata = wdata; exp_wmask = wmask;
        i_command_valid = 1'b1; i_write = wr; i_read = !wr;
        i_address = addr; i_write_data = wdata; i_write_mask = wmask;
        junk_regs();
        if (early) begin
            @(posedge clk); #1;
        end
        n = cyc;
        if (active == '0) begin
            len = 1; r.status = 2'b11; r.data = '0;
        end else if (delay < TO) begin
            len = delay + 1; r.status = 2'b00; r.data = '0;
            for (int i = 0; i < NR; i++) begin
                if (rdy[i]) begin
                    r.status = r.status | reg_st[i];
                    r.data   = r.data | reg_rd[i];
                end
            end
            if (wr) r.data = '0;
        end else begin
            len = TO; r.status = 2'b01; r.data = '0;
        end
        r.cycle = n + 1 + len;
        exp_q.push_back(r);
        @(posedge clk); #1;
        exp_access = 1'b1;
        for (int k = 0; k < len; k++) begin
            i_command_valid = 1'($urandom); i_write = 1'($urandom); i_read = 1'($urandom);
            i_address = AW'($urandom); i_write_data = $urandom; i_write_mask = $urandom;
            drive_regs(active, (k == delay) ? rdy : '0);
            @(posedge clk); #1;
        end
        exp_access = 1'b0;
        i_command_valid = 1'b0;
        junk_regs();
    endtask

    task automatic set_regs(input logic [DW-1:0] d0, d1, d2, input logic [1:0] s0, s1, s2);
        reg_rd[0] = d0; reg_rd[1] = d1; reg_rd[2] = d2;
        reg_st[0] = s0; reg_st[1] = s1; reg_st[2] = s2;
    endtask

    initial begin
        rst_n = 1'b0;
        i_command_valid = 1'b0; i_write = 1'b0; i_read = 1'b0;
        i_address = '0; i_write_data = '0; i_write_mask = '0;
        junk_regs();
        @(posedge clk); #1;
        vectors++;
        if ({o_response_ready, o_read_data, o_status, o_register_valid, o_register_write,
             o_register_address, o_register_write_data, o_register_write_mask} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rr=%b rd=%h st=%b v=%b want all zero",
                     o_response_ready, o_read_data, o_status, o_register_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        set_regs(32'h1111_0000, 32'hDEADBEEF, 32'h0000_2222, 2'b01, 2'b00, 2'b01);
        run_cmd(1'b0, 16'h0004, 32'h0, 32'h0, 3'b010, 3'b010, 0, 1'b0, 0);
        run_cmd(1'b1, 16'h0010, 32'h12345678, 32'h0000FFFF, 3'b001, 3'b001, 2, 1'b0, 0);
        run_cmd(1'b0, 16'h0FF0, 32'h0, 32'h0, 3'b000, 3'b000, 0, 1'b0, 1);
        run_cmd(1'b0, 16'h0020, 32'h0, 32'h0, 3'b100, 3'b100, 99, 1'b0, 0);
        set_regs(32'hA5A5_0001, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00);
        run_cmd(1'b0, 16'h0020, 32'h0, 32'h0, 3'b001, 3'b001, 3, 1'b0, 0);
        run_cmd(1'b0, 16'h0000, 32'h0, 32'h0, 3'b001, 3'b001, 0, 1'b0, 0);
        run_cmd(1'b1, 16'h0004, 32'hCAFEF00D, 32'hFFFFFFFF, 3'b001, 3'b001, 1, 1'b1, 0);
        run_cmd(1'b0, 16'h0000, 32'h0, 32'h0, 3'b001, 3'b001, 0, 1'b0, 0);

        // Abort mid-access with reset: no response, outputs clear at once.
        @(posedge clk); #1;
        exp_write = 1'b0; exp_address = 16'h0008; exp_wdata = 32'h0; exp_wmask = 32'h0;
        i_command_valid = 1'b1; i_write = 1'b0; i_read = 1'b1;
        i_address = 16'h0008; i_write_data = '0; i_write_mask = '0;
        @(posedge clk); #1;
        exp_access = 1'b1;
        i_command_valid = 1'b0;
        drive_regs(3'b001, 3'b000);
        #2;
        rst_n = 1'b0;
        exp_access = 1'b0;
        #1;
        vectors++;
        if ({o_response_ready, o_read_data, o_status, o_register_valid, o_register_write,
             o_register_address, o_register_write_data, o_register_write_mask} !== '0) begin
            errors++;
            $display("FAIL async_reset: got rr=%b rd=%h st=%b v=%b a=%h want all zero",
                     o_response_ready, o_read_data, o_status, o_register_valid, o_register_address);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_regs(32'h0BAD_F00D, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00);
        run_cmd(1'b0, 16'h0008, 32'h0, 32'h0, 3'b001, 3'b001, 0, 1'b0, 0);

        for (int t = 0; t < 150; t++) begin
            logic [NR-1:0] act;
            set_regs($urandom, $urandom, $urandom, 2'($urandom), 2'($urandom), 2'($urandom));
            act = ($urandom_range(0, 7) == 0) ? '0 : NR'($urandom);
            run_cmd(1'($urandom), AW'($urandom), $urandom, $urandom, act, NR'($urandom),
                    $urandom_range(0, 5), 1'($urandom), $urandom_range(0, 2));
        end

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_responses: got %0d outstanding want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
